// File: rtl/processor_pkg.sv
// Shared definitions for the 8-bit accumulator-less processor core.
// Holds opcode encodings, FSM state encodings, instruction field bit
// positions and a decode helper used by the core.
package processor_pkg;

  // Instruction word layout: op=[7:6], rs=[5:4], rt=[3:2], rd/imm=[1:0]
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_HALT  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    opcode_e    op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;  // doubles as the LOAD/STORE immediate
  } instr_t;

  function automatic instr_t decode(input logic [7:0] word);
    instr_t f;
    f.op = opcode_e'(word[OP_MSB:OP_LSB]);
    f.rs = word[RS_MSB:RS_LSB];
    f.rt = word[RT_MSB:RT_LSB];
    f.rd = word[RD_MSB:RD_LSB];
    return f;
  endfunction

endpackage

// File: rtl/processor_core_reg_file.sv
// reg_file: 4 x 8-bit register file.
// Ports:
//   clk, clear          - clock, synchronous active-high reset (all regs to 0)
//   ra_addr / ra_data   - combinational read port A
//   rb_addr / rb_data   - combinational read port B
//   we, waddr, wdata    - synchronous write port
//   r0..r3              - register contents for observation
// Reads return the pre-write value in the cycle of a write, so an
// instruction whose destination matches a source sees the old value.
module reg_file (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3
);

  logic [3:0][7:0] regs_q;
  logic [3:0][7:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (clear) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign r0      = regs_q[0];
  assign r1      = regs_q[1];
  assign r2      = regs_q[2];
  assign r3      = regs_q[3];

endmodule

// File: rtl/processor_core.sv
// processor_core: two-cycle-per-instruction 8-bit processor.
// FETCH latches the instruction at address=PC into IR; EXEC performs
// ADD / LOAD / STORE and advances PC, or enters HALT and stays there
// until clear.
// Ports:
//   clk, clear             - clock, synchronous active-high reset
//   address, instruction   - instruction memory (combinational read)
//   dmem_addr, dmem_rdata  - data memory read (combinational)
//   dmem_wdata, dmem_we    - data memory write, strobe only in STORE EXEC
//   halted                 - high once HALT has executed
//   r0..r3                 - register contents for observation
//   dbg_state              - current FSM state (state_e encoding)
// Memory interface has no handshake: memories answer combinationally in
// the same cycle, and dmem_we is a single-cycle write strobe.
module processor_core
  import processor_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  output logic [7:0] dmem_addr,
  input  logic [7:0] dmem_rdata,
  output logic [7:0] dmem_wdata,
  output logic       dmem_we,
  output logic       halted,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3,
  output logic [1:0] dbg_state
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  instr_t     ir;
  logic [7:0] rs_val;
  logic [7:0] rt_val;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       store_exec;

  assign ir = decode(ir_q);

  reg_file u_reg_file (
    .clk     (clk),
    .clear   (clear),
    .ra_addr (ir.rs),
    .ra_data (rs_val),
    .rb_addr (ir.rt),
    .rb_data (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rf_we      = 1'b0;
    rf_waddr   = ir.rd;
    rf_wdata   = rs_val + rt_val;
    store_exec = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d    = pc_q + 8'd1;
        state_d = ST_FETCH;
        case (ir.op)
          OP_ADD: rf_we = 1'b1;
          OP_LOAD: begin
            rf_we    = 1'b1;
            rf_waddr = ir.rt;
            rf_wdata = dmem_rdata;
          end
          OP_STORE: store_exec = 1'b1;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
    // clear wins over a mid-instruction EXEC: no write of any kind.
    if (clear) begin
      rf_we      = 1'b0;
      store_exec = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_FETCH;
      pc_q    <= 8'd0;
      ir_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign address    = pc_q;
  assign dmem_addr  = rs_val + {6'b0, ir.rd};
  assign dmem_wdata = rt_val;
  assign dmem_we    = store_exec;
  assign halted     = (state_q == ST_HALT);
  assign dbg_state  = state_q;

endmodule
